// File: rtl/spi_ram_pkg.sv
// spi_ram shared definitions.
// Command codes and frame layout.
package spi_ram_pkg;

  localparam int CMD_W   = 2;
  localparam int PAY_LSB = 0;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  // Command field sits just above the payload.
  function automatic int cmd_lsb(input int data_size);
    return data_size;
  endfunction

endpackage

// File: rtl/spi_ram_if.sv
// spi_ram frame bus.
// Connects the SPI slave rx/tx side to the RAM.
interface spi_ram_if #(
  parameter int DATA_SIZE = 8
);

  logic [DATA_SIZE+1:0] din;
  logic                 rx_valid;
  logic [DATA_SIZE-1:0] dout;
  logic                 tx_valid;
  logic                 cmd_err;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  cmd_err
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output cmd_err
  );

endinterface

// File: rtl/spi_ram_array.sv
// spi_ram storage array.
// Sync write port, registered read port.
module spi_ram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds the last word read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/spi_ram.sv
// spi_ram top: command decode and pointers.
// Frames from SPI slave, read data back out.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input logic        clk,
  input logic        rst_n,
  spi_ram_if.slave   bus
);

  localparam int CMD_LSB = cmd_lsb(DATA_SIZE);

  localparam logic [DATA_SIZE:0] DEPTH_V =
    (DATA_SIZE+1)'(MEM_DEPTH);

  localparam logic [ADDR_SIZE-1:0] LAST =
    ADDR_SIZE'(MEM_DEPTH - 1);

  cmd_e                 cmd;
  logic [DATA_SIZE-1:0] pay;
  logic                 in_rng;

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 wr_vld;
  logic                 rd_vld;

  logic                 set_wp;
  logic                 set_rp;
  logic                 we;
  logic                 re;
  logic                 err;

  logic                 tx_valid_q;
  logic                 cmd_err_q;

  assign cmd    = cmd_e'(bus.din[CMD_LSB +: CMD_W]);
  assign pay    = bus.din[PAY_LSB +: DATA_SIZE];
  assign in_rng = {1'b0, pay} < DEPTH_V;

  function automatic logic [ADDR_SIZE-1:0] inc(
    input logic [ADDR_SIZE-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Decode one command per strobed edge.
  always_comb begin
    set_wp = 1'b0;
    set_rp = 1'b0;
    we     = 1'b0;
    re     = 1'b0;
    err    = 1'b0;
    if (bus.rx_valid) begin
      unique case (1'b1)
        (cmd == CMD_WR_ADDR): begin
          set_wp = in_rng;
          err    = !in_rng;
        end
        (cmd == CMD_WR_DATA): begin
          we  = wr_vld;
          err = !wr_vld;
        end
        (cmd == CMD_RD_ADDR): begin
          set_rp = in_rng;
          err    = !in_rng;
        end
        (cmd == CMD_RD_DATA): begin
          re  = rd_vld;
          err = !rd_vld;
        end
        default: begin
          err = 1'b1;
        end
      endcase
    end
  end

  // Pointers, valid flags and one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_vld     <= 1'b0;
      rd_vld     <= 1'b0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      tx_valid_q <= re;
      cmd_err_q  <= err;
      if (set_wp) begin
        wr_ptr <= pay[ADDR_SIZE-1:0];
        wr_vld <= 1'b1;
      end else if (we && AUTO_INC != 0) begin
        wr_ptr <= inc(wr_ptr);
      end
      if (set_rp) begin
        rd_ptr <= pay[ADDR_SIZE-1:0];
        rd_vld <= 1'b1;
      end else if (re && AUTO_INC != 0) begin
        rd_ptr <= inc(rd_ptr);
      end
    end
  end

  spi_ram_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE),
    .DW    (DATA_SIZE)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (pay),
    .re    (re),
    .raddr (rd_ptr),
    .rdata (bus.dout)
  );

  assign bus.tx_valid = tx_valid_q;
  assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// spi_ram directed bench.
// Three configs: default, depth 200, auto-inc.
module tb_spi_ram;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spi_ram_if #(.DATA_SIZE(8)) ba ();
  spi_ram_if #(.DATA_SIZE(8)) br ();
  spi_ram_if #(.DATA_SIZE(8)) bi ();

  spi_ram #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8),
    .DATA_SIZE (8),
    .AUTO_INC  (0)
  ) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ba.slave)
  );

  spi_ram #(
    .MEM_DEPTH (200),
    .ADDR_SIZE (8),
    .DATA_SIZE (8),
    .AUTO_INC  (0)
  ) u_r (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (br.slave)
  );

  spi_ram #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8),
    .DATA_SIZE (8),
    .AUTO_INC  (1)
  ) u_i (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic look(
    input int         u,
    input string      tag,
    input logic [7:0] d,
    input logic       t,
    input logic       e
  );
    logic [7:0] gd;
    logic       gt;
    logic       ge;
    case (u)
      0: begin gd = ba.dout; gt = ba.tx_valid; ge = ba.cmd_err; end
      1: begin gd = br.dout; gt = br.tx_valid; ge = br.cmd_err; end
      default: begin
        gd = bi.dout; gt = bi.tx_valid; ge = bi.cmd_err;
      end
    endcase
    chk({tag, ".dout"}, 32'(gd), 32'(d));
    chk({tag, ".tx"},   32'(gt), 32'(t));
    chk({tag, ".err"},  32'(ge), 32'(e));
  endtask

  task automatic send(input int u, input logic [9:0] f);
    case (u)
      0: begin ba.din = f; ba.rx_valid = 1'b1; end
      1: begin br.din = f; br.rx_valid = 1'b1; end
      default: begin bi.din = f; bi.rx_valid = 1'b1; end
    endcase
    @(negedge clk);
    ba.rx_valid = 1'b0;
    br.rx_valid = 1'b0;
    bi.rx_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    ba.din = '0; ba.rx_valid = 1'b0;
    br.din = '0; br.rx_valid = 1'b0;
    bi.din = '0; bi.rx_valid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    look(0, "rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    look(0, "post_rst", 8'h00, 1'b0, 1'b0);

    // read with no read address
    send(0, 10'b11_00000000);
    look(0, "rd_novld", 8'h00, 1'b0, 1'b1);
    idle();
    look(0, "rd_novld_n", 8'h00, 1'b0, 1'b0);

    // round trip
    send(0, 10'b00_00000101);
    look(0, "wa5", 8'h00, 1'b0, 1'b0);
    send(0, 10'b01_10100101);
    look(0, "wdA5", 8'h00, 1'b0, 1'b0);
    send(0, 10'b10_00000101);
    look(0, "ra5", 8'h00, 1'b0, 1'b0);
    send(0, 10'b11_00000000);
    look(0, "rdA5", 8'hA5, 1'b1, 1'b0);
    idle();
    look(0, "rdA5_n", 8'hA5, 1'b0, 1'b0);

    // pointer independence and no auto-inc
    send(0, 10'b00_00010000);
    send(0, 10'b01_00111100);
    send(0, 10'b11_00000000);
    look(0, "rd_again", 8'hA5, 1'b1, 1'b0);
    send(0, 10'b10_00010000);
    send(0, 10'b11_00000000);
    look(0, "rd10", 8'h3C, 1'b1, 1'b0);
    send(0, 10'b00_00000000);
    send(0, 10'b01_01000100);
    send(0, 10'b10_00000000);
    send(0, 10'b11_11111111);
    look(0, "rd0", 8'h44, 1'b1, 1'b0);

    // reset right after a read strobe
    send(0, 10'b10_00000101);
    send(0, 10'b11_00000000);
    look(0, "pre_mid", 8'hA5, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    look(0, "mid_rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 10'b11_00000000);
    look(0, "rd_clr", 8'h00, 1'b0, 1'b1);
    send(0, 10'b01_01011010);
    look(0, "wd_clr", 8'h00, 1'b0, 1'b1);
    send(0, 10'b10_00000000);
    send(0, 10'b11_00000000);
    look(0, "no_wr", 8'h44, 1'b1, 1'b0);

    // depth 200 range checks
    send(1, {2'b00, 8'd250});
    look(1, "wa250", 8'h00, 1'b0, 1'b1);
    send(1, 10'b01_01110111);
    look(1, "wd_oor", 8'h00, 1'b0, 1'b1);
    send(1, {2'b10, 8'd200});
    look(1, "ra200", 8'h00, 1'b0, 1'b1);
    send(1, {2'b10, 8'd199});
    look(1, "ra199", 8'h00, 1'b0, 1'b0);
    send(1, {2'b00, 8'd199});
    look(1, "wa199", 8'h00, 1'b0, 1'b0);
    send(1, 10'b01_10011100);
    look(1, "wd199", 8'h00, 1'b0, 1'b0);
    send(1, 10'b11_00000000);
    look(1, "rd199", 8'h9C, 1'b1, 1'b0);

    // auto-increment wrap
    send(2, {2'b00, 8'd255});
    send(2, 10'b01_00010001);
    send(2, 10'b01_00100010);
    look(2, "inc_wr", 8'h00, 1'b0, 1'b0);
    send(2, {2'b10, 8'd255});
    send(2, 10'b11_00000000);
    look(2, "inc_rd0", 8'h11, 1'b1, 1'b0);
    send(2, 10'b11_00000000);
    look(2, "inc_rd1", 8'h22, 1'b1, 1'b0);
    idle();
    look(2, "inc_idle", 8'h22, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
